mem_port_arbiter: RTL and testbench

//   Shares the CPU's single memory port between the instruction-fetch and data (load/store) requesters.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and unified-memory signals.
// master = arbiter view; slave = the surrounding core/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              bus_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Handshake: a requester holds req (and its fields) until a one-cycle ready
  // pulse; the arbiter holds mem_req and mem_* stable until mem_ack, whose
  // cycle also carries mem_rdata. bus_err qualifies the ready pulse.
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses, one
// transaction at a time, data-first with a fetch anti-starvation counter and a watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  mem_port_arbiter_if.master bus,
  output logic [1:0] dbg_state,
  output logic [3:0] dbg_starve_cnt
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t     state;
  logic       owner_d;
  logic [3:0] starve_cnt;
  logic [7:0] wd_cnt;
  logic       grant_data;

  always_comb begin
    grant_data = bus.d_req && !(bus.if_req && (starve_cnt == STARVE_LIM));
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      starve_cnt   <= '0;
      wd_cnt       <= '0;
      bus.if_ready <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_ready  <= 1'b0;
      bus.d_rdata  <= '0;
      bus.bus_err  <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be   <= '0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      bus.bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            owner_d     <= grant_data;
            bus.mem_req <= 1'b1;
            wd_cnt      <= '0;
            state       <= BUSY;
            if (grant_data) begin
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_be    <= bus.d_we ? bus.d_be : {BE_W{1'b1}};
              if (bus.if_req && (starve_cnt != STARVE_LIM))
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= '0;
              bus.mem_be    <= {BE_W{1'b1}};
              starve_cnt    <= '0;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= RESP;
            if (owner_d) begin
              bus.d_rdata <= bus.mem_rdata;
              bus.d_ready <= 1'b1;
            end else begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ready <= 1'b1;
            end
          end else if (wd_cnt == WD_LAST) begin
            // Hung access: complete it with an error and zero data.
            bus.mem_req <= 1'b0;
            bus.bus_err <= 1'b1;
            state       <= RESP;
            if (owner_d) begin
              bus.d_rdata <= '0;
              bus.d_ready <= 1'b1;
            end else begin
              bus.if_rdata <= '0;
              bus.if_ready <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX=3, TIMEOUT=8).
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [3:0] dbg_starve_cnt;

  int n_total = 0;
  int n_bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(3), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // driver: a complete fetch with an ack in the first BUSY cycle
  task automatic run_fetch(input string tag, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    tick();
    check({tag, "_mem_req"}, 64'(bus.mem_req), 64'd1);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(addr));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    tick();
    check({tag, "_if_ready"}, 64'(bus.if_ready), 64'd1);
    check({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'(data));
    check({tag, "_bus_err"}, 64'(bus.bus_err), 64'd0);
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    check({tag, "_if_ready_low"}, 64'(bus.if_ready), 64'd0);
  endtask

  localparam logic [7:0] GRANT_D = 8'b0111_0111;

  initial begin
    int cnt;
    logic [3:0] starve_tab [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [DATA_W-1:0] popped;

    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_ready", 64'({bus.if_ready, bus.d_ready, bus.bus_err}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
    rst = 1'b0;

    // Lone fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    check("t1_mem_req", 64'(bus.mem_req), 64'd1);
    check("t1_mem_addr", 64'(bus.mem_addr), 64'h100);
    check("t1_mem_we", 64'(bus.mem_we), 64'd0);
    check("t1_mem_be", 64'(bus.mem_be), 64'hF);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
    tick();
    check("t1_if_ready", 64'(bus.if_ready), 64'd1);
    check("t1_if_rdata", 64'(bus.if_rdata), 64'h0050_0093);
    check("t1_d_ready", 64'(bus.d_ready), 64'd0);
    check("t1_mem_req_low", 64'(bus.mem_req), 64'd0);
    bus.if_req = 1'b0; bus.mem_ack = 1'b0;
    tick();
    check("t1_if_ready_low", 64'(bus.if_ready), 64'd0);

    // Stray ack in IDLE
    bus.mem_ack = 1'b1;
    tick();
    check("t6_idle_ready", 64'({bus.if_ready, bus.d_ready}), 64'd0);
    check("t6_idle_state", 64'(dbg_state), 64'd0);
    check("t6_idle_mem_req", 64'(bus.mem_req), 64'd0);
    bus.mem_ack = 1'b0;

    // Store with one wait cycle; stray ack during RESP
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2004;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'h3;
    tick();
    check("t2_mem_we", 64'(bus.mem_we), 64'd1);
    check("t2_mem_be", 64'(bus.mem_be), 64'h3);
    check("t2_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    check("t2_mem_addr", 64'(bus.mem_addr), 64'h2004);
    tick();
    check("t2_hold_req", 64'(bus.mem_req), 64'd1);
    check("t2_hold_addr", 64'(bus.mem_addr), 64'h2004);
    check("t2_no_ready", 64'(bus.d_ready), 64'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    check("t2_d_ready", 64'(bus.d_ready), 64'd1);
    check("t2_if_ready", 64'(bus.if_ready), 64'd0);
    check("t2_if_rdata_kept", 64'(bus.if_rdata), 64'h0050_0093);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick();
    check("t6_resp_ready", 64'({bus.if_ready, bus.d_ready}), 64'd0);
    check("t6_resp_state", 64'(dbg_state), 64'd0);
    bus.mem_ack = 1'b0;

    // Contention: both held high
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.d_be = 4'h3;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t3_grant%0d_addr", i), 64'(bus.mem_addr),
            GRANT_D[i] ? 64'h500 : 64'h400);
      check($sformatf("t3_grant%0d_be", i), 64'(bus.mem_be), 64'hF);
      check($sformatf("t3_grant%0d_starve", i), 64'(dbg_starve_cnt), 64'(starve_tab[i]));
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1000 + 32'(i);
      exp_q.push_back(32'h1000 + 32'(i));
      tick();
      bus.mem_ack = 1'b0;
      popped = exp_q.pop_front();
      check($sformatf("t3_grant%0d_ready", i), 64'({bus.d_ready, bus.if_ready}),
            GRANT_D[i] ? 64'd2 : 64'd1);
      check($sformatf("t3_grant%0d_rdata", i),
            64'(GRANT_D[i] ? bus.d_rdata : bus.if_rdata), 64'(popped));
      tick();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;

    // Watchdog on a load
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000;
    tick();
    check("t4_mem_req", 64'(bus.mem_req), 64'd1);
    cnt = 1;
    for (int i = 0; i < 20 && bus.mem_req; i++) begin
      tick();
      if (bus.mem_req) cnt++;
    end
    check("t4_req_dropped", 64'(bus.mem_req), 64'd0);
    check("t4_req_cycles", 64'(cnt), 64'd8);
    check("t4_d_ready", 64'(bus.d_ready), 64'd1);
    check("t4_bus_err", 64'(bus.bus_err), 64'd1);
    check("t4_d_rdata", 64'(bus.d_rdata), 64'd0);
    check("t4_if_ready", 64'(bus.if_ready), 64'd0);
    bus.d_req = 1'b0;
    tick();
    check("t4_ready_low", 64'({bus.d_ready, bus.bus_err}), 64'd0);
    run_fetch("t4_next", 32'h700, 32'hCAFE_0001);

    // Reset during BUSY
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    tick();
    check("t5_mem_req", 64'(bus.mem_req), 64'd1);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("t5_req_async_low", 64'(bus.mem_req), 64'd0);
    check("t5_state", 64'(dbg_state), 64'd0);
    tick();
    check("t5_no_ready", 64'({bus.if_ready, bus.d_ready, bus.bus_err}), 64'd0);
    rst = 1'b0;
    run_fetch("t5_after", 32'h600, 32'hA5A5_5A5A);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
